dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the 5-stage RISC-V core, sitting on the memory-stage side of the load/store path. It accepts one load or store request at a time over a valid/ready channel and applies a configurable number of wait states. It performs the byte-masked word access, then returns read data and an error flag over a valid/ready response channel. This lets the memory stage be exercised against realistic multi-cycle memory latency instead of a zero-wait array.

## Interface
- `DEPTH`, 1024, number of 32-bit words stored.
- `WAIT_CYCLES`, 2, wait states inserted between request acceptance and the memory access; legal range 0..15.
- `clk` in 1, sole clock; all state changes on its rising edge.
- `rst` in 1, asynchronous, active-low reset.
- `req_valid` in 1, request present.
- `req_ready` out 1, responder can accept a request.
- `req_we` in 1, 1 = store, 0 = load.
- `req_be` in 4, byte enables for stores; bit i selects bits [8i+7:8i]; ignored for loads.
- `req_addr` in 32, byte address.
- `req_wdata` in 32, store data.
- `resp_valid` out 1, response present.
- `resp_ready` in 1, memory stage accepts the response.
- `resp_rdata` out 32, load data; 0 for stores and errors.
- `resp_err` out 1, request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid` && `req_ready`, latch we, be, addr, wdata.
  - If `WAIT_CYCLES` = 0, go to RESP and perform the access on this edge.
  - Otherwise, go to WAIT with the counter = `WAIT_CYCLES` - 1.
- WAIT:
  - If counter = 0, perform the access and go to RESP.
  - Otherwise, decrement the counter.
  - Counter width is $clog2(WAIT_CYCLES+1), minimum 1 bit.
- Access:
  - Word index = addr[31:2].
  - Error if addr[1:0] != 0 or word index >= `DEPTH`.
  - On error: no array write, rdata = 0, err = 1.
  - Store: write only the bytes whose be bit is set. be = 4'b0000 is a legal no-op store (err = 0).
  - Load: full word returned, be ignored.
  - rdata and err are registered into response holding registers on the access edge.
- RESP:
  - `resp_valid` = 1.
  - `resp_rdata` and `resp_err` are held stable until `resp_valid` && `resp_ready`, then go to IDLE.
- Single outstanding transaction. `req_ready` = 0 in WAIT and RESP; requests offered there are ignored, not queued.
- Array contents are not cleared by reset. A load from a never-written word returns X in simulation; the bench must not depend on it.

## Timing
- Reset (rst = 0, immediate):
  - State goes to IDLE and the counter to 0.
  - `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
  - An in-flight access is abandoned.
  - A store not yet performed (still in WAIT) does not write the array.
  - A store already performed stays written.
- Latency:
  - The acceptance edge ends cycle 0.
  - `resp_valid` is first high in cycle `WAIT_CYCLES` + 1, i.e. cycle 3 for the default.
- Store commit edge equals the edge on which `resp_valid` rises.
- After the response handshake edge, `req_ready` is 1 in the next cycle. Minimum spacing between acceptances is `WAIT_CYCLES` + 2 cycles; there is no back-to-back bypass.
- If `resp_ready` is already 1 when `resp_valid` rises, `resp_valid` is high for exactly one cycle.
- `req_ready` and `resp_valid` are decoded from the state register only; neither depends combinationally on the inputs.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - the byte-lane width constant (8);
  - the error-check function (alignment + range vs `DEPTH`).
- One sub-module, `dmem_array`, contains:
  - DEPTH x 32 storage;
  - per-byte write enable;
  - synchronous write and combinational read of the latched index.
- FSM, counter, request latches and response registers live in `dmem_responder`.

## Test plan
- Store-then-load, default parameters:
  - Store addr 0x10, wdata 0xDEADBEEF, be 4'hF. Response is `resp_valid` in cycle 3, err 0, rdata 0.
  - Then load 0x10. Response is rdata 0xDEADBEEF, err 0.
- Byte-masked store:
  - Over 0xDEADBEEF at 0x10, store wdata 0x11223344 with be 4'b0101.
  - A load of 0x10 returns 0xDE22BE44.
- Errors:
  - Load at 0x12 returns err 1, rdata 0.
  - A store at byte address 4*`DEPTH` returns err 1, and a later load of word 0 is unchanged.
- Response backpressure:
  - Hold `resp_ready` = 0 for 5 cycles after `resp_valid`. rdata and err must stay stable, `req_ready` must stay 0, and a new `req_valid` must be ignored.
  - After `resp_ready` = 1, `req_ready` = 1 in the next cycle.
- Reset mid-operation:
  - Assert rst during WAIT of a store to 0x20 with 0xCAFEF00D. Outputs go to reset values immediately.
  - After release, a load of 0x20 returns its prior value (pre-written 0x0).
- `WAIT_CYCLES` = 0 build:
  - Store then load 0x0 with 0x12345678. Each `resp_valid` appears in cycle 1 after acceptance, and the load returns 0x12345678.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types, constants and the address check used by the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_LANES = WORD_W / BYTE_W;

    // Misaligned byte address or word index beyond the array both flag an error.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] widx;
        widx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (widx >= depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the memory stage (master) and the responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Word-organised storage with per-byte write enables and a combinational read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IW    = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [NUM_LANES-1:0] be,
    input  logic [IW-1:0]        idx,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (be[i]) begin
                    mem[idx][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait states, held response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int unsigned CW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    state_t state, state_nxt;
    logic [CW-1:0] cnt;

    logic                 lat_we;
    logic [NUM_LANES-1:0] lat_be;
    logic [31:0]          lat_addr;
    logic [WORD_W-1:0]    lat_wdata;

    logic [WORD_W-1:0] resp_rdata_q;
    logic              resp_err_q;

    logic                 accept;
    logic                 do_access;
    logic                 acc_we;
    logic [NUM_LANES-1:0] acc_be;
    logic [31:0]          acc_addr;
    logic [WORD_W-1:0]    acc_wdata;
    logic                 acc_err;
    logic                 mem_we;
    logic [WORD_W-1:0]    mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cnt == '0) state_nxt = RESP;
            RESP: if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    assign accept = (state == IDLE) && bus.req_valid;

    // With zero wait states the access happens on the acceptance edge, so the
    // live request fields are used instead of the not-yet-loaded latches.
    always_comb begin
        do_access = 1'b0;
        acc_we    = lat_we;
        acc_be    = lat_be;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (WAIT_CYCLES == 0) begin
            do_access = accept;
            acc_we    = bus.req_we;
            acc_be    = bus.req_be;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end else begin
            do_access = (state == WAIT) && (cnt == '0);
        end
    end

    assign acc_err = addr_err(acc_addr, DEPTH);
    assign mem_we  = do_access && acc_we && !acc_err && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            lat_we       <= 1'b0;
            lat_be       <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_be    <= bus.req_be;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                cnt       <= CW'(CNT_INIT);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (do_access) begin
                resp_rdata_q <= (acc_we || acc_err) ? '0 : mem_rdata;
                resp_err_q   <= acc_err;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (acc_be),
        .idx   (acc_addr[IW+1:2]),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default build plus a zero-wait-state build.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    // Drives one request with resp_ready held high; lat = -1 if no response within 20 cycles.
    task automatic xact(input bit sel0, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic rv_after, output logic rr_after);
        @(negedge clk);
        if (sel0) begin
            bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_be = be;
            bus0.req_addr = addr; bus0.req_wdata = wdata; bus0.resp_ready = 1'b1;
        end else begin
            bus.req_valid = 1'b1; bus.req_we = we; bus.req_be = be;
            bus.req_addr = addr; bus.req_wdata = wdata; bus.resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus0.req_valid = 1'b0;
        lat = -1;
        rdata = '0;
        err = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (sel0 ? bus0.resp_valid : bus.resp_valid) begin
                lat = c;
                break;
            end
        end
        rdata = sel0 ? bus0.resp_rdata : bus.resp_rdata;
        err   = sel0 ? bus0.resp_err : bus.resp_err;
        @(negedge clk);
        rv_after = sel0 ? bus0.resp_valid : bus.resp_valid;
        rr_after = sel0 ? bus0.req_ready : bus.req_ready;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #3;
        tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
        tests_run++; if (bus.resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        tests_run++; if (bus.resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
        tests_run++; if (bus.resp_err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %b want 0", bus.resp_err); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er, rv, rr;
        xact(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, er, rv, rr);
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL st_latency: got %0d want 3", lat); end
        tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL st_err: got %b want 0", er); end
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL st_rdata: got %h want 0", rd); end
        tests_run++; if (rv !== 1'b0) begin tests_failed++; $display("FAIL st_one_cycle_valid: got %b want 0", rv); end
        tests_run++; if (rr !== 1'b1) begin tests_failed++; $display("FAIL st_ready_after: got %b want 1", rr); end
        xact(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er, rv, rr);
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL ld_latency: got %0d want 3", lat); end
        tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL ld_rdata: got %h want deadbeef", rd); end
        tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL ld_err: got %b want 0", er); end
    endtask

    task automatic test_byte_mask();
        int lat; logic [31:0] rd; logic er, rv, rr;
        xact(1'b0, 1'b1, 4'b0101, 32'h10, 32'h11223344, lat, rd, er, rv, rr);
        xact(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, lat, rd, er, rv, rr);
        tests_run++; if (rd !== 32'hDE22BE44) begin tests_failed++; $display("FAIL mask_rdata: got %h want de22be44", rd); end
        xact(1'b0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, lat, rd, er, rv, rr);
        tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL noop_err: got %b want 0", er); end
        xact(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er, rv, rr);
        tests_run++; if (rd !== 32'hDE22BE44) begin tests_failed++; $display("FAIL noop_rdata: got %h want de22be44", rd); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er, rv, rr;
        xact(1'b0, 1'b1, 4'hF, 32'h0, 32'hA5A55A5A, lat, rd, er, rv, rr);
        xact(1'b0, 1'b0, 4'h0, 32'h12, 32'h0, lat, rd, er, rv, rr);
        tests_run++; if (er !== 1'b1) begin tests_failed++; $display("FAIL misalign_err: got %b want 1", er); end
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL misalign_rdata: got %h want 0", rd); end
        xact(1'b0, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, lat, rd, er, rv, rr);
        tests_run++; if (er !== 1'b1) begin tests_failed++; $display("FAIL range_err: got %b want 1", er); end
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL range_latency: got %0d want 3", lat); end
        xact(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, lat, rd, er, rv, rr);
        tests_run++; if (rd !== 32'hA5A55A5A) begin tests_failed++; $display("FAIL word0_rdata: got %h want a5a55a5a", rd); end
        tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL word0_err: got %b want 0", er); end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic er, rv, rr;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_be = 4'h0;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin lat = c; break; end
        end
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL bp_latency: got %0d want 3", lat); end
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_be = 4'hF;
            bus.req_addr = 32'h10; bus.req_wdata = 32'hFFFFFFFF;
            @(negedge clk);
            tests_run++; if (bus.resp_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.resp_valid); end
            tests_run++; if (bus.resp_rdata !== 32'hDE22BE44) begin tests_failed++; $display("FAIL bp_rdata[%0d]: got %h want de22be44", i, bus.resp_rdata); end
            tests_run++; if (bus.resp_err !== 1'b0) begin tests_failed++; $display("FAIL bp_err[%0d]: got %b want 0", i, bus.resp_err); end
            tests_run++; if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, bus.req_ready); end
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %b want 1", bus.req_ready); end
        tests_run++; if (bus.resp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release_valid: got %b want 0", bus.resp_valid); end
        xact(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er, rv, rr);
        tests_run++; if (rd !== 32'hDE22BE44) begin tests_failed++; $display("FAIL bp_ignored_store: got %h want de22be44", rd); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er, rv, rr;
        xact(1'b0, 1'b1, 4'hF, 32'h20, 32'h0, lat, rd, er, rv, rr);
        xact(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er, rv, rr);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_be = 4'hF;
        bus.req_addr = 32'h20; bus.req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_wait_ready: got %b want 0", bus.req_ready); end
        #1 rst = 1'b0;
        #1;
        tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_ready: got %b want 1", bus.req_ready); end
        tests_run++; if (bus.resp_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid: got %b want 0", bus.resp_valid); end
        tests_run++; if (bus.resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL mid_rst_rdata: got %h want 0", bus.resp_rdata); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        xact(1'b0, 1'b0, 4'h0, 32'h20, 32'h0, lat, rd, er, rv, rr);
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL mid_abandoned_store: got %h want 0", rd); end
        tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL mid_load_err: got %b want 0", er); end
    endtask

    task automatic test_zero_wait();
        int lat; logic [31:0] rd; logic er, rv, rr;
        xact(1'b1, 1'b1, 4'hF, 32'h0, 32'h12345678, lat, rd, er, rv, rr);
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL zw_st_latency: got %0d want 1", lat); end
        tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL zw_st_err: got %b want 0", er); end
        tests_run++; if (rv !== 1'b0) begin tests_failed++; $display("FAIL zw_one_cycle_valid: got %b want 0", rv); end
        xact(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, lat, rd, er, rv, rr);
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL zw_ld_latency: got %0d want 1", lat); end
        tests_run++; if (rd !== 32'h12345678) begin tests_failed++; $display("FAIL zw_ld_rdata: got %h want 12345678", rd); end
        tests_run++; if (rr !== 1'b1) begin tests_failed++; $display("FAIL zw_ready_after: got %b want 1", rr); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_be = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_be = '0;
        bus0.req_addr = '0; bus0.req_wdata = '0; bus0.resp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_byte_mask();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_zero_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
